// File: rtl/readout_seq_pkg.sv
// Shared types and size/offset helpers for the readout byte sequencer.
// Build option SEQ_CHECKSUM_EN is consumed by readout_byte_seq, not here.
package readout_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  localparam int FPGA_OFS = 0;
  localparam int VER_OFS  = 1;

  function automatic int calc_nsel(int nver, int nch, int cbytes);
    return 3 + nver + nch * cbytes;
  endfunction

  // One spare code so the optional checksum byte can carry index NSEL.
  function automatic int calc_iw(int nver, int nch, int cbytes);
    return $clog2(calc_nsel(nver, nch, cbytes) + 1);
  endfunction

  function automatic int penc_ofs(int nver);
    return 1 + nver;
  endfunction

  function automatic int cntr_ofs(int nver);
    return 2 + nver;
  endfunction

  function automatic int dac_ofs(int nver, int nch, int cbytes);
    return 2 + nver + nch * cbytes;
  endfunction

endpackage

// File: rtl/readout_sel_dec.sv
// Combinational index-to-select decoder; active-low one-hot, all ones when disabled.
module readout_sel_dec #(
  parameter int NSEL = 24,
  parameter int IW   = 5
) (
  input  logic [IW-1:0]   idx,
  input  logic            en,
  output logic [NSEL-1:0] sel_n
);

  always_comb begin
    sel_n = '1;
    for (int i = 0; i < NSEL; i++) begin
      if (en && idx == IW'(i)) sel_n[i] = 1'b0;
    end
  end

endmodule

// File: rtl/readout_byte_seq.sv
// Walks every readout byte in select-map order and streams it out over valid/ready.
// Define SEQ_CHECKSUM_EN to append an XOR checksum byte (out_idx = NSEL) after the DAC byte.
//
// state | meaning
// IDLE  | waiting for start, all selects released
// SEL   | one select low, wait counter running, capture on terminal count
// HOLD  | byte presented on out_*, waiting for out_ready
// DONE  | one-cycle done pulse, then back to IDLE
module readout_byte_seq
  import readout_seq_pkg::*;
#(
  parameter int NVER    = 5,
  parameter int NCH     = 4,
  parameter int CBYTES  = 4,
  parameter int DW      = 8,
  parameter int RD_WAIT = 1,
  localparam int NSEL   = calc_nsel(NVER, NCH, CBYTES),
  localparam int IW     = calc_iw(NVER, NCH, CBYTES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [NSEL-1:0] sel_n,
  input  logic [DW-1:0]   rd_data,
  output logic [DW-1:0]   out_data,
  output logic [IW-1:0]   out_idx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done
);

  localparam int CW = 4;
  localparam logic [IW-1:0] DAC_IDX = IW'(dac_ofs(NVER, NCH, CBYTES));
`ifdef SEQ_CHECKSUM_EN
  localparam logic [IW-1:0] LAST_IDX = IW'(NSEL);
`else
  localparam logic [IW-1:0] LAST_IDX = DAC_IDX;
`endif

  seq_state_e      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q;
  logic            abort_q;
  logic [NSEL-1:0] sel_d;
  logic            capture, accept, stop;

  assign capture = (state_q == SEL) && !abort && (cnt_q == '0);
  assign accept  = (state_q == HOLD) && out_ready;
  // An abort seen while holding a byte is remembered until the handshake.
  assign stop    = abort || abort_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEL;
          idx_d   = '0;
        end
      end
      SEL: begin
        if (abort)              state_d = IDLE;
        else if (cnt_q == '0)   state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (stop)                    state_d = IDLE;
          else if (idx_q == LAST_IDX)  state_d = DONE;
`ifdef SEQ_CHECKSUM_EN
          else if (idx_q == DAC_IDX) begin
            state_d = HOLD;
            idx_d   = LAST_IDX;
          end
`endif
          else begin
            state_d = SEL;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Decode the next state so the select register lines up with the SEL state.
  readout_sel_dec #(.NSEL(NSEL), .IW(IW)) u_sel_dec (
    .idx   (idx_d),
    .en    (state_d == SEL),
    .sel_n (sel_d)
  );

`ifdef SEQ_CHECKSUM_EN
  logic [DW-1:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 csum_q <= '0;
    else if (state_q == IDLE)   csum_q <= '0;
    else if (capture)           csum_q <= csum_q ^ rd_data;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_n     <= '1;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
    end else begin
      sel_n   <= sel_d;
      abort_q <= (state_q == HOLD) && stop && !accept;
      if (state_q != SEL)      cnt_q <= CW'(RD_WAIT - 1);
      else if (cnt_q != '0)    cnt_q <= cnt_q - CW'(1);
      if (capture) begin
        out_data  <= rd_data;
        out_idx   <= idx_q;
        out_valid <= 1'b1;
      end else if (accept) begin
`ifdef SEQ_CHECKSUM_EN
        if (!stop && idx_q == DAC_IDX) begin
          out_data <= csum_q;
          out_idx  <= LAST_IDX;
        end else begin
          out_valid <= 1'b0;
        end
`else
        out_valid <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_readout_byte_seq.sv
// Scoreboard bench for readout_byte_seq: directed timing cases plus randomized ready/abort runs.
// Honors SEQ_CHECKSUM_EN when the design is built with it.
module tb_readout_byte_seq;

  localparam int NSEL  = 24;
  localparam int NSEL2 = 9;
`ifdef SEQ_CHECKSUM_EN
  localparam int TOTAL     = 25;
  localparam int TOTAL2    = 10;
  localparam int EXP_DONE  = 50;
  localparam int EXP_DONE2 = 38;
`else
  localparam int TOTAL     = 24;
  localparam int TOTAL2    = 9;
  localparam int EXP_DONE  = 49;
  localparam int EXP_DONE2 = 37;
`endif
  localparam logic [NSEL-1:0] ALL1 = {NSEL{1'b1}};

  logic clk = 1'b0;
  logic rst_n, start, abort, out_ready, out_valid, busy, done;
  logic [NSEL-1:0] sel_n;
  logic [7:0] rd_data, out_data;
  logic [4:0] out_idx;

  logic start2, out_valid2, busy2, done2;
  logic [NSEL2-1:0] sel_n2;
  logic [7:0] out_data2;
  logic [3:0] out_idx2;
  logic [7:0] rd_data2 = 8'h00;
  logic out_ready2 = 1'b1;
  logic abort2 = 1'b0;

  always #5 clk = ~clk;

  readout_byte_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sel_n(sel_n),
    .rd_data(rd_data), .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  readout_byte_seq #(.NVER(2), .NCH(2), .CBYTES(2), .DW(8), .RD_WAIT(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .sel_n(sel_n2),
    .rd_data(rd_data2), .out_data(out_data2), .out_idx(out_idx2), .out_valid(out_valid2),
    .out_ready(out_ready2), .busy(busy2), .done(done2)
  );

  // Byte source model: whichever select is low returns its table entry.
  logic [7:0] tab [NSEL];
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NSEL; i++) if (!sel_n[i]) rd_data = tab[i];
  end

  int checks = 0, errors = 0;
  int exp_next, nbytes, done_count;
  bit aborted, seen_first;
  logic [NSEL-1:0] first_sel, last_sel;
  logic [7:0] last_data;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] xor_all();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < NSEL; i++) x ^= tab[i];
    return x;
  endfunction

  // Every-cycle compare against the expected byte stream.
  initial begin
    logic pv, pr;
    logic [7:0] pd;
    logic [4:0] pi;
    int zc, zi;
    pv = 1'b0; pr = 1'b0; pd = '0; pi = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        zc = 0; zi = -1;
        for (int i = 0; i < NSEL; i++) if (!sel_n[i]) begin zc++; zi = i; end
        chk("sel_onehot", zc <= 1, 1);
        if (zi >= 0) begin
          chk("sel_pos", zi, exp_next);
          chk("sel_while_valid", out_valid, 0);
          if (!seen_first) first_sel = sel_n;
          seen_first = 1'b1;
          last_sel = sel_n;
        end
        if (out_valid) chk("valid_busy", busy, 1);
        if (pv && !pr) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, pd);
          chk("stall_idx", out_idx, pi);
        end
        if (out_valid && out_ready) begin
          chk("byte_in_range", exp_next < TOTAL, 1);
          chk("byte_idx", out_idx, exp_next);
          chk("byte_data", out_data, (exp_next < NSEL) ? tab[exp_next] : xor_all());
          last_data = out_data;
          exp_next++;
          nbytes++;
        end
        if (done) begin
          done_count++;
          chk("done_all_bytes", exp_next, TOTAL);
          chk("done_not_aborted", aborted, 0);
        end
        pv = out_valid; pr = out_ready; pd = out_data; pi = out_idx;
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    exp_next = 0; nbytes = 0; done_count = 0;
    aborted = 1'b0; seen_first = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (!busy) return;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_byte(input logic [4:0] idx);
    for (int n = 0; n < 500; n++) begin
      @(posedge clk); #1;
      if (out_valid && out_idx == idx) return;
    end
    chk("byte_timeout", out_idx, idx);
  endtask

  task automatic ramp_tab();
    for (int i = 0; i < NSEL; i++) tab[i] = 8'(i + 8'h40);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1; start2 = 1'b0;
    exp_next = 0; nbytes = 0; done_count = 0; aborted = 1'b0; seen_first = 1'b0;
    first_sel = ALL1; last_sel = ALL1; last_data = '0;
    ramp_tab();
    repeat (2) @(posedge clk); #1;
    chk("rst_sel", sel_n, ALL1);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    // Full sequence, ready always high.
    do_start();
    n = 1;
    while (n < 300) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    chk("done_cycle", n, EXP_DONE);
    wait_idle();
    chk("full_nbytes", nbytes, TOTAL);
    chk("full_first_sel", first_sel, 24'hFFFFFE);
    chk("full_last_sel", last_sel, 24'h7FFFFF);
    chk("full_done_count", done_count, 1);

    // Ready stall on idx 7.
    do_start();
    wait_byte(5'd7);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall7_sel", sel_n, ALL1);
      chk("stall7_idx", out_idx, 7);
      chk("stall7_data", out_data, 8'h47);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle();
    chk("stall_nbytes", nbytes, TOTAL);
    chk("stall_done_count", done_count, 1);

    // Abort during SEL of idx 3, then restart.
    do_start();
    for (int k = 0; k < 100 && sel_n[3]; k++) begin @(posedge clk); #1; end
    chk("sel3_reached", sel_n[3], 0);
    abort = 1'b1; aborted = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("absel_sel", sel_n, ALL1);
    chk("absel_busy", busy, 0);
    chk("absel_valid", out_valid, 0);
    repeat (3) @(posedge clk); #1;
    chk("absel_nbytes", nbytes, 3);
    chk("absel_done", done_count, 0);
    do_start();
    wait_idle();
    chk("restart_nbytes", nbytes, TOTAL);

    // Abort in HOLD of idx 10 with ready low; a stray start is ignored.
    do_start();
    wait_byte(5'd10);
    out_ready = 1'b0; abort = 1'b1; aborted = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abhold_valid", out_valid, 1);
      chk("abhold_busy", busy, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("abhold_valid_drop", out_valid, 0);
    chk("abhold_busy_drop", busy, 0);
    repeat (4) @(posedge clk); #1;
    chk("abhold_nbytes", nbytes, 11);
    chk("abhold_done", done_count, 0);
    chk("abhold_stays_idle", busy, 0);

    // Randomized data, ready and aborts.
    for (int s = 0; s < 16; s++) begin
      int ab_at, cyc;
      for (int i = 0; i < NSEL; i++) tab[i] = 8'($urandom);
      ab_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 60)) : -1;
      do_start();
      for (cyc = 1; cyc < 3000; cyc++) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
        if (cyc == ab_at && busy && !done) begin
          abort = 1'b1; aborted = 1'b1;
        end else begin
          abort = 1'b0;
        end
        if (!busy) break;
      end
      abort = 1'b0; out_ready = 1'b1;
      chk("rand_ended", busy, 0);
      if (aborted) chk("rand_abort_done", done_count, 0);
      else begin
        chk("rand_nbytes", nbytes, TOTAL);
        chk("rand_done_count", done_count, 1);
      end
    end

`ifdef SEQ_CHECKSUM_EN
    for (int i = 0; i < NSEL; i++) tab[i] = 8'hA5;
    do_start();
    wait_idle();
    chk("csum_nbytes", nbytes, 25);
    chk("csum_value", last_data, 8'h00);
    chk("csum_done", done_count, 1);
`endif

    // Asynchronous reset in the middle of a byte.
    ramp_tab();
    do_start();
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_sel", sel_n, ALL1);
    chk("arst_data", out_data, 0);
    chk("arst_idx", out_idx, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Small configuration: NSEL 9, three-cycle selects, DAC on bit 8.
    begin
      int cur, run, expk, lastbit, bytes2, z;
      cur = -1; run = 0; expk = 0; lastbit = -1; bytes2 = 0;
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      n = 1;
      while (n < 300) begin
        @(negedge clk);
        z = -1;
        for (int i = 0; i < NSEL2; i++) if (!sel_n2[i]) z = i;
        if (out_valid2) bytes2++;
        if (z != cur) begin
          if (cur >= 0) begin
            chk("cfg2_hold_len", run, 3);
            chk("cfg2_order", cur, expk);
            expk++;
            lastbit = cur;
          end
          cur = z;
          run = (z >= 0) ? 1 : 0;
        end else if (z >= 0) begin
          run++;
        end
        if (done2) break;
        n++;
      end
      chk("cfg2_done_cycle", n, EXP_DONE2);
      chk("cfg2_nsel", expk, 9);
      chk("cfg2_dac_bit", lastbit, 8);
      chk("cfg2_nbytes", bytes2, TOTAL2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
